// File: rtl/pipe_adder_pkg.sv
// Shared defaults and stage-count helper for the segmented pipelined adder.
package pipe_adder_pkg;

    localparam int DEF_BIT_WIDTH = 32;
    localparam int DEF_SEG_WIDTH = 8;

    function automatic int num_seg(input int bit_width, input int seg_width);
        return bit_width / seg_width;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/seg_adder.sv
// Combinational ripple adder for one pipeline segment, built from full_adder cells.
module seg_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/pipe_adder_nbit.sv
// Segmented pipelined adder/subtractor with global-stall valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder_nbit
    import pipe_adder_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 sub,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int NUM_SEG = num_seg(BIT_WIDTH, SEG_WIDTH);
    localparam int S       = SEG_WIDTH;

    logic                 advance;
    logic [BIT_WIDTH-1:0] b_eff;
    logic                 c_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign b_eff    = sub ? ~b : b;
    assign c_eff    = sub | cin;

    // Stage k adds segment k; operand regs shrink and sum regs grow per stage.
    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        logic [S-1:0]       seg_a;
        logic [S-1:0]       seg_b;
        logic [S-1:0]       seg_s;
        logic               seg_ci;
        logic               seg_co;
        logic               v_in;
        logic               v_d;
        logic               v_q;
        logic               c_d;
        logic               c_q;
        logic [(k+1)*S-1:0] s_d;
        logic [(k+1)*S-1:0] s_q;

        if (k == 0) begin : g_src
            assign seg_a  = a[S-1:0];
            assign seg_b  = b_eff[S-1:0];
            assign seg_ci = c_eff;
            assign v_in   = in_valid;
            always_comb s_d = seg_s;
        end else begin : g_src
            assign seg_a  = g_stage[k-1].g_op.a_q[k*S +: S];
            assign seg_b  = g_stage[k-1].g_op.b_q[k*S +: S];
            assign seg_ci = g_stage[k-1].c_q;
            assign v_in   = g_stage[k-1].v_q;
            always_comb s_d = {seg_s, g_stage[k-1].s_q};
        end

        seg_adder #(
            .WIDTH (S)
        ) u_seg (
            .a    (seg_a),
            .b    (seg_b),
            .cin  (seg_ci),
            .sum  (seg_s),
            .cout (seg_co)
        );

        always_comb begin
            v_d = v_in;
            c_d = seg_co;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (advance) begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        if (k < NUM_SEG - 1) begin : g_op
            logic [BIT_WIDTH-1:(k+1)*S] a_d;
            logic [BIT_WIDTH-1:(k+1)*S] a_q;
            logic [BIT_WIDTH-1:(k+1)*S] b_d;
            logic [BIT_WIDTH-1:(k+1)*S] b_q;

            if (k == 0) begin : g_in
                assign a_d = a[BIT_WIDTH-1:S];
                assign b_d = b_eff[BIT_WIDTH-1:S];
            end else begin : g_in
                assign a_d = g_stage[k-1].g_op.a_q[BIT_WIDTH-1:(k+1)*S];
                assign b_d = g_stage[k-1].g_op.b_q[BIT_WIDTH-1:(k+1)*S];
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_out
            assign sum       = s_q;
            assign cout      = c_q;
            assign out_valid = v_q;
`ifdef PIPE_ADDER_OVF_EN
            logic ovf_d;
            logic ovf_q;

            // a^b^s at the MSB recovers the carry into the MSB
            always_comb ovf_d = seg_a[S-1] ^ seg_b[S-1] ^ seg_s[S-1] ^ seg_co;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end

            assign ovf = ovf_q;
`endif
        end
    end

endmodule

// File: doc/pipe_adder_nbit.md
PIPE_ADDER_NBIT -- requirements
Module: pipe_adder_nbit

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter SEG_WIDTH, default 8: bits added per pipeline stage; BIT_WIDTH SHALL be an integer multiple of SEG_WIDTH; NUM_SEG = BIT_WIDTH/SEG_WIDTH.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand beat valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-007 SHALL have port a, input, BIT_WIDTH: operand A.
REQ-008 SHALL have port b, input, BIT_WIDTH: operand B.
REQ-009 SHALL have port sub, input, 1: 0 = A+B, 1 = A-B (two's complement).
REQ-010 SHALL have port cin, input, 1: carry-in; ignored when sub=1.
REQ-011 SHALL have port out_valid, output, 1: result beat valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-013 SHALL have port sum, output, BIT_WIDTH: result.
REQ-014 SHALL have port cout, output, 1: carry out of MSB (for sub: 1 = no borrow).

Function
REQ-015 SHALL add one SEG_WIDTH segment per stage, LSB segment first; stage k's carry-out SHALL feed stage k+1 carry-in via register.
REQ-016 SHALL, for sub=1, add ~b with stage-0 carry-in 1; for sub=0, stage-0 carry-in = cin.
REQ-017 SHALL carry unprocessed operand segments and completed sum segments forward in per-stage registers (operand skew/deskew) so each beat leaves with all BIT_WIDTH bits aligned.
REQ-018 SHALL have fixed latency NUM_SEG cycles from accepted beat (in_valid & in_ready) to out_valid, absent backpressure.
REQ-019 SHALL accept one beat per cycle; throughput 1 beat/cycle when out_ready held high.
REQ-020 SHALL use global-stall flow control: advance = !out_valid | out_ready; in_ready = advance; pipeline holds all stages when advance=0.
REQ-021 SHALL keep sum, cout, out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL track per-stage valid bits; bubbles (in_valid=0 while advancing) SHALL propagate as invalid stages, never as results.
REQ-023 SHALL, when NUM_SEG=1, behave as a single-register adder with latency 1.
REQ-024 SHALL wrap modulo 2^BIT_WIDTH; overflow reported only via cout (and ovf, REQ-028).
REQ-025 SHALL accept a new beat on the same cycle a result is consumed (out_valid & out_ready & in_valid) with no lost or duplicated beat.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, clear all stage valid bits; out_valid=0, sum=0, cout=0 after reset; in_ready=1 the cycle after rst deasserts.
REQ-027 SHALL discard any in-flight beats on reset mid-operation; no result of a pre-reset beat ever appears.

Configuration
REQ-028 With PIPE_ADDER_OVF_EN defined, SHALL add output port ovf, 1 bit, aligned with sum: signed overflow = carry into MSB XOR carry out of MSB, reset 0.
REQ-029 Without PIPE_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 SHALL place default widths and a function computing NUM_SEG in shared package pipe_adder_pkg.
REQ-031 SHALL instantiate one sub-module seg_adder (SEG_WIDTH-bit combinational add with cin/cout, built from the existing full_adder cell) per stage via generate loop.

Verification (BIT_WIDTH=32, SEG_WIDTH=8, latency 4)
REQ-032 SHALL check: a=0x0000_00FF, b=0x0000_0001, sub=0, cin=0 -> sum=0x0000_0100, cout=0 four cycles later.
REQ-033 SHALL check: a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> sum=0x0000_0000, cout=1; with OVF_EN, a=0x7FFF_FFFF, b=1 -> ovf=1.
REQ-034 SHALL check: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-035 SHALL check: 100 back-to-back random beats with out_ready randomly toggled -> results in order, match reference model, stable while stalled, in_ready=0 exactly when out_valid=1 & out_ready=0.
REQ-036 SHALL check: rst asserted for one cycle with 3 beats in flight -> out_valid=0 next cycle, none of the 3 results ever emitted, next beat after reset returns correctly after 4 cycles.
